pipe_csah: RTL
==============

PIPE_CSAH -- requirements
Module: pipe_csah

Interface
REQ-001 Parameter N, default 128: operand and sum width in bits.
REQ-002 Parameter M, default 32: chunk width per pipeline stage; N SHALL be an integer multiple of M, with M >= 4.
REQ-003 Derived L = N/M: number of pipeline stages and the latency in cycles.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  operand set presented.
REQ-007 in_ready  output  1  block accepts the operand set this cycle.
REQ-008 a  input  N  operand A.
REQ-009 b  input  N  operand B.
REQ-010 cin  input  1  carry in; ignored when sub=1.
REQ-011 sub  input  1  1 = compute a - b, i.e. a + ~b + 1.
REQ-012 s  output  N  sum or difference.
REQ-013 cout  output  1  carry out of bit N-1.
REQ-014 gen  output  1  group generate of the full N-bit operation, with b already inverted when sub=1.
REQ-015 prop  output  1  group propagate of the full N-bit operation, with b already inverted when sub=1.
REQ-016 out_valid  output  1  s, cout, gen and prop are valid.
REQ-017 out_ready  input  1  downstream accepts the result.

Function
REQ-018 A transfer in SHALL occur when in_valid && in_ready are both high on a rising edge; a transfer out SHALL occur when out_valid && out_ready are both high.
REQ-019 Stage k (0..L-1) SHALL compute chunk k, bits [k*M+M-1 : k*M], as follows:
- form both the carry-0 and carry-1 sums of the chunk;
- select between them using the carry registered from stage k-1, or the effective cin for k=0;
- produce the chunk generate and propagate.
REQ-020 The effective carry in SHALL be (sub ? 1 : cin), and the effective B SHALL be (sub ? ~b : b); both are captured at transfer in.
REQ-021 Operand chunks not yet consumed SHALL travel with the transaction through skew registers, and completed sum chunks SHALL travel with it through deskew registers, so that s is presented aligned.
REQ-022 Group gen and prop SHALL accumulate stage by stage:
- G = g_k | (p_k & G_prev)
- P = p_k & P_prev
REQ-023 Each stage SHALL hold a valid bit; stage k SHALL load when it is empty or when stage k+1 loads in the same cycle; the last stage SHALL advance when out_ready is high or when out_valid is low.
REQ-024 in_ready SHALL equal the load condition of stage 0, i.e. combinational backpressure with no bubble when the pipeline is full and advancing.
REQ-025 Latency SHALL be exactly L cycles from transfer in to out_valid when no stall occurs; sustained throughput SHALL be one result per cycle.
REQ-026 While out_valid=1 and out_ready=0, s, cout, gen, prop and out_valid SHALL hold stable, and no transaction SHALL be lost or duplicated.
REQ-027 Arithmetic SHALL be modulo 2^N; cout SHALL carry the overflow, and for sub=1, cout=1 SHALL mean a >= b (unsigned).
REQ-028 When out_ready=1 and in_valid=1 every cycle, an accept and an output SHALL occur in the same cycle with no gap.

Reset
REQ-029 While rst_n=0, all valid bits, out_valid, s, cout, gen, prop and all pipeline data registers SHALL be 0, and in_ready SHALL be 0.
REQ-030 From the first rising edge after rst_n deasserts, in_ready SHALL be 1.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight transactions immediately; no stale result SHALL appear after release.

Verification (N=128, M=32, L=4)
REQ-032 a=2^128-1, b=0, cin=1, sub=0, out_ready=1 -> after 4 cycles: s=0, cout=1, gen=0, prop=1.
REQ-033 a=5, b=7, sub=1 -> s=2^128-2, cout=0; then a=7, b=5, sub=1 -> s=2, cout=1.
REQ-034 Stream 10 random transactions back-to-back with out_ready=1 -> 10 consecutive out_valid cycles, in order, each matching the reference model (a+b+cin or a-b).
REQ-035 Fill the pipeline, then hold out_ready=0 for 6 cycles -> in_ready=0 once 4 transactions are in flight, and the output stays stable; release out_ready -> results drain in order, none dropped.
REQ-036 Assert rst_n=0 with 3 transactions in flight -> out_valid=0 immediately and s=0; after release, no output appears until a new transaction completes 4 cycles after its acceptance.
REQ-037 Carry crossing every chunk boundary, a=2^96-1, b=1, cin=0 -> s=2^96, cout=0, gen=0, prop=0.

Source files
------------

// File: rtl/pipe_csah.sv
// Pipelined carry-select adder/subtractor: one M-bit chunk per stage. Operands
// are skewed in and sum chunks deskewed out, so s emerges aligned after L cycles.
module pipe_csah #(
  parameter int N = 128,
  parameter int M = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         gen,
  output logic         prop,
  output logic         out_valid,
  input  logic         out_ready
);
  localparam int L = N / M;

  logic         run_q;
  logic [L-1:0] v_q;
  logic [L-1:0] ld;
  logic [N-1:0] a_q [L];
  logic [N-1:0] b_q [L];
  logic [N-1:0] s_q [L];
  logic [L-1:0] c_q;
  logic [L-1:0] g_q;
  logic [L-1:0] p_q;

  // Keeps in_ready low until the first edge after reset release.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  // A stage loads when empty or when its successor loads this cycle.
  always_comb begin
    ld[L-1] = ~v_q[L-1] | out_ready;
    for (int k = L - 2; k >= 0; k--) ld[k] = ~v_q[k] | ld[k+1];
  end

  assign in_ready = run_q & ld[0];

  for (genvar k = 0; k < L; k++) begin : g_stage
    logic [N-1:0] a_i, b_i, s_i, s_nxt;
    logic         c_i, g_i, p_i, v_i;
    logic [M-1:0] ach, bch;
    logic [M:0]   sum0, sum1, sel;
    logic         gk, pk;

    if (k == 0) begin : g_head
      assign a_i = a;
      assign b_i = sub ? ~b : b;
      assign c_i = sub | cin;
      assign s_i = '0;
      assign g_i = 1'b0;
      assign p_i = 1'b1;
      assign v_i = in_valid & in_ready;
    end else begin : g_body
      assign a_i = a_q[k-1];
      assign b_i = b_q[k-1];
      assign c_i = c_q[k-1];
      assign s_i = s_q[k-1];
      assign g_i = g_q[k-1];
      assign p_i = p_q[k-1];
      assign v_i = v_q[k-1];
    end

    assign ach  = a_i[k*M +: M];
    assign bch  = b_i[k*M +: M];
    assign sum0 = {1'b0, ach} + {1'b0, bch};
    assign sum1 = {1'b0, ach} + {1'b0, bch} + {{M{1'b0}}, 1'b1};
    assign sel  = c_i ? sum1 : sum0;
    assign gk   = sum0[M];
    assign pk   = &(ach ^ bch);

    // NOTE: s_nxt gets a full default before the chunk overwrite, so no latch is inferred.
    always_comb begin
      s_nxt = s_i;
      s_nxt[k*M +: M] = sel[M-1:0];
    end

    // NOTE: data registers are reset with the valid bits so no stale operand or sum survives reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        g_q[k] <= 1'b0;
        p_q[k] <= 1'b0;
      end else if (ld[k]) begin
        v_q[k] <= v_i;
        if (v_i) begin
          a_q[k] <= a_i;
          b_q[k] <= b_i;
          s_q[k] <= s_nxt;
          c_q[k] <= sel[M];
          g_q[k] <= gk | (pk & g_i);
          p_q[k] <= pk & p_i;
        end
      end
    end
  end

  assign out_valid = v_q[L-1];
  assign s         = s_q[L-1];
  assign cout      = c_q[L-1];
  assign gen       = g_q[L-1];
  assign prop      = p_q[L-1];

endmodule
